// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: state codes, frame length and default timing constants.
// Used by the host transmitter and intended for the matching receiver.
package ps2_host_tx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RTS   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam int FRAME_LEN          = 11;
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

    // Odd parity above the data byte; shifted out LSB first.
    function automatic logic [8:0] make_pkt(input logic [7:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: two-flop synchronizer, FILTER_LEN-sample glitch filter
// and a registered one-cycle falling-edge strobe.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK,
    input  logic reset,
    input  logic ps2c_in,
    output logic level,
    output logic fall
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] hist;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync  <= 2'b11;
            hist  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], ps2c_in};
            hist <= {hist[FILTER_LEN-2:0], sync[1]};
            fall <= 1'b0;
            // Level only moves once the whole history window agrees.
            if (&hist) begin
                level <= 1'b1;
            end else if (hist == '0) begin
                level <= 1'b0;
                fall  <= level;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: RTS inhibit, start/data/parity/stop, ACK check.
// Optional watchdog between device clock falls enabled by defining PS2_TX_WATCHDOG_EN.
//
// state | meaning
// IDLE  | lines released, waiting for wr_ps2
// RTS   | clock held low for INHIBIT_CYCLES (request to send)
// START | clock released, data pulled low as start bit
// DATA  | presenting pkt[0]; shifts on each device clock fall
// STOP  | data released as stop bit; next fall samples device ACK
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    logic [2:0]    state, state_nx;
    logic [8:0]    pkt, pkt_nx;
    logic [3:0]    n, n_nx;
    logic [IW-1:0] icnt, icnt_nx;
    logic [1:0]    d_sync;
    logic          fall, c_level_unused;
    logic          done_nx, err_nx, wd_expire;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .CLK     (CLK),
        .reset   (reset),
        .ps2c_in (ps2c_in),
        .level   (c_level_unused),
        .fall    (fall)
    );

`ifdef PS2_TX_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wcnt;

    assign wd_expire = (state == ST_START || state == ST_DATA || state == ST_STOP)
                       && (wcnt == '0) && !fall;

    // Reloaded on every state change and every clock fall; counts down otherwise.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wcnt <= '0;
        end else if (state_nx != state || fall) begin
            wcnt <= WW'(TIMEOUT_CYCLES - 1);
        end else if (wcnt != '0) begin
            wcnt <= wcnt - WW'(1);
        end
    end
`else
    logic wd_unused;
    assign wd_unused = |TIMEOUT_CYCLES;
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) d_sync <= 2'b11;
        else       d_sync <= {d_sync[0], ps2d_in};
    end

    always_comb begin
        state_nx = state;
        pkt_nx   = pkt;
        n_nx     = n;
        icnt_nx  = icnt;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            ST_IDLE: if (wr_ps2) begin
                pkt_nx   = make_pkt(din);
                icnt_nx  = IW'(INHIBIT_CYCLES - 1);
                state_nx = ST_RTS;
            end
            ST_RTS: begin
                if (icnt == '0) state_nx = ST_START;
                else            icnt_nx  = icnt - IW'(1);
            end
            ST_START: if (fall) begin
                n_nx     = 4'd0;
                state_nx = ST_DATA;
            end
            ST_DATA: if (fall) begin
                if (n == 4'd8) begin
                    state_nx = ST_STOP;
                end else begin
                    pkt_nx = {1'b0, pkt[8:1]};
                    n_nx   = n + 4'd1;
                end
            end
            ST_STOP: if (fall) begin
                done_nx  = ~d_sync[1];
                err_nx   = d_sync[1];
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (wd_expire) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b0;
            err_nx   = 1'b1;
        end
    end

    // Outputs are registered from the next-state values so they align with state.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pkt          <= '0;
            n            <= '0;
            icnt         <= '0;
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_idle      <= 1'b1;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
        end else begin
            state        <= state_nx;
            pkt          <= pkt_nx;
            n            <= n_nx;
            icnt         <= icnt_nx;
            ps2c_oe      <= (state_nx == ST_RTS);
            ps2d_oe      <= (state_nx == ST_START) || (state_nx == ST_DATA && !pkt_nx[0]);
            tx_idle      <= (state_nx == ST_IDLE);
            tx_done_tick <= done_nx;
            tx_err_tick  <= err_nx;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx: a behavioural PS/2 device drives the clock
// and samples the data line; a monitor pops expected outcomes on every tick.
module tb_ps2_host_tx;

    localparam int INHIBIT = 5000;
    localparam int FLEN    = 8;
    localparam int TOUT    = 3000;
    localparam int HP      = 40;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;

    // Open-drain lines: low if either side pulls.
    assign ps2c_in = ~ps2c_oe & dev_c;
    assign ps2d_in = ~ps2d_oe & dev_d;

    always #5 CLK = ~CLK;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c_in      (ps2c_in),
        .ps2d_in      (ps2d_in),
        .ps2c_oe      (ps2c_oe),
        .ps2d_oe      (ps2d_oe),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err_tick  (tx_err_tick)
    );

    typedef struct packed {
        logic [9:0] bits;
        logic       is_err;
        logic       chk_bits;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] dev_bits = '0;
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line values the device should see after falls 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic [9:0] f;
        f[7:0] = d;
        f[8]   = ($countones(d) % 2 == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    always @(negedge CLK) begin
        if (!reset && (tx_done_tick || tx_err_tick)) begin
            check("tick_exclusive", 32'(tx_done_tick & tx_err_tick), 0);
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_tick: done=%0b err=%0b with no frame outstanding",
                         tx_done_tick, tx_err_tick);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_err", 32'(tx_err_tick), 32'(mon_e.is_err));
                check("tick_done", 32'(tx_done_tick), 32'(!mon_e.is_err));
                if (mon_e.chk_bits) check("frame_bits", 32'(dev_bits), 32'(mon_e.bits));
            end
        end
    end

    // inject: 1 = wr_ps2 with din 0 during DATA, 2 = reset at fall 5, 3 = clock glitch.
    task automatic device(input int stop_after, input int inject, input bit ack, input bit check_inhibit);
        int         cnt;
        logic [9:0] bits;
        bits = '0;
        cnt = 0;
        while (ps2c_oe !== 1'b1 && cnt < 20) begin
            @(negedge CLK);
            cnt++;
        end
        check("rts_seen", 32'(ps2c_oe), 1);
        cnt = 0;
        while (ps2c_oe === 1'b1 && cnt < INHIBIT + 100) begin
            @(negedge CLK);
            cnt++;
        end
        if (check_inhibit) check("inhibit_len", 32'(cnt), INHIBIT);
        check("start_bit", 32'(ps2d_oe), 1);
        repeat (HP) @(negedge CLK);
        for (int f = 1; f <= 11; f++) begin
            if (f == 11) dev_d = ack ? 1'b0 : 1'b1;
            dev_c = 1'b0;
            if (inject == 2 && f == 5) begin
                #2;
                reset = 1'b1;
                #1;
                check("rst_mid_c_oe", 32'(ps2c_oe), 0);
                check("rst_mid_d_oe", 32'(ps2d_oe), 0);
                check("rst_mid_idle", 32'(tx_idle), 1);
                check("rst_mid_ticks", 32'({tx_done_tick, tx_err_tick}), 0);
                dev_c = 1'b1;
                dev_d = 1'b1;
                return;
            end
            if (inject == 1 && f == 3) begin
                repeat (15) @(negedge CLK);
                din    = 8'h00;
                wr_ps2 = 1'b1;
                @(negedge CLK);
                wr_ps2 = 1'b0;
                repeat (HP - 16) @(negedge CLK);
            end else begin
                repeat (HP) @(negedge CLK);
            end
            if (f <= 10) bits[f-1] = ps2d_in;
            if (f == 10) dev_bits = bits;
            dev_c = 1'b1;
            if (f == 11) dev_d = 1'b1;
            if (f == stop_after) return;
            if (inject == 3 && f == 4) begin
                repeat (10) @(negedge CLK);
                dev_c = 1'b0;
                repeat (3) @(negedge CLK);
                dev_c = 1'b1;
                repeat (HP - 13) @(negedge CLK);
            end else begin
                repeat (HP) @(negedge CLK);
            end
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input bit push, input bit ack);
        int cnt;
        exp_t e;
        cnt = 0;
        while (tx_idle !== 1'b1 && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        check("idle_before_wr", 32'(tx_idle), 1);
        din    = d;
        wr_ps2 = 1'b1;
        if (push) begin
            e.bits     = ref_frame(d);
            e.is_err   = !ack;
            e.chk_bits = 1'b1;
            exp_q.push_back(e);
        end
        @(negedge CLK);
        wr_ps2 = 1'b0;
        din    = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input int inject);
        int cnt;
        start_frame(d, 1'b1, ack);
        device(0, inject, ack, 1'b1);
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        check("tick_arrived", 32'(exp_q.size()), 0);
        repeat (5) @(negedge CLK);
        check("idle_after", 32'(tx_idle), 1);
        check("lines_released", 32'({ps2c_oe, ps2d_oe}), 0);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] sd;
        exp_t       e;
        int         cnt;

        repeat (3) @(negedge CLK);
        check("rst_c_oe", 32'(ps2c_oe), 0);
        check("rst_d_oe", 32'(ps2d_oe), 0);
        check("rst_idle", 32'(tx_idle), 1);
        check("rst_done", 32'(tx_done_tick), 0);
        check("rst_err", 32'(tx_err_tick), 0);
        reset = 1'b0;
        repeat (20) @(negedge CLK);

        send(8'hF4, 1'b1, 1);
        send(8'hED, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            rd = 8'($urandom);
            send(rd, 1'($urandom_range(0, 1)), (k == 0) ? 3 : 0);
        end

        // Abort mid-frame with reset; any tick afterwards is unexpected.
        start_frame(8'($urandom), 1'b0, 1'b1);
        device(0, 2, 1'b1, 1'b1);
        repeat (5) @(negedge CLK);
        reset = 1'b0;
        repeat (200) @(negedge CLK);
        check("idle_after_rst", 32'(tx_idle), 1);

        // Device goes silent after fall 4 while d3 is on the line.
        sd = 8'($urandom);
`ifdef PS2_TX_WATCHDOG_EN
        start_frame(sd, 1'b0, 1'b1);
        e.bits     = '0;
        e.is_err   = 1'b1;
        e.chk_bits = 1'b0;
        exp_q.push_back(e);
        device(4, 0, 1'b1, 1'b1);
        cnt = 0;
        while (exp_q.size() > 0 && cnt < TOUT + 200) begin
            @(negedge CLK);
            cnt++;
        end
        check("wd_err_tick", 32'(exp_q.size()), 0);
        check("wd_c_released", 32'(ps2c_oe), 0);
        check("wd_d_released", 32'(ps2d_oe), 0);
        check("wd_idle", 32'(tx_idle), 1);
`else
        start_frame(sd, 1'b0, 1'b1);
        device(4, 0, 1'b1, 1'b1);
        repeat (2 * TOUT) @(negedge CLK);
        check("stall_not_idle", 32'(tx_idle), 0);
        check("stall_holds_d3", 32'(ps2d_oe), 32'(!sd[3]));
        check("stall_c_released", 32'(ps2c_oe), 0);
        cnt = exp_q.size();
        check("stall_no_tick", 32'(cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
